// File: rtl/feature_streamer.sv
// Feature streamer: buffers one IMG_ROWS x IMG_COLS frame loaded byte-by-byte and streams it
// row-major over a valid/ready port. Optional macro FEATURE_STREAMER_TEST_PATTERN_EN substitutes a counting pattern.
module feature_streamer #(
  parameter int IMG_ROWS   = 32,
  parameter int IMG_COLS   = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_load_valid,
  input  logic [DATA_WIDTH-1:0]       i_load_data,
  output logic                        o_load_ready,
  output logic                        o_loaded,
  input  logic                        i_start,
  input  logic                        i_ready_feature,
  output logic                        o_feature_valid,
  output logic [DATA_WIDTH-1:0]       o_feature,
  output logic                        o_busy,
  output logic                        o_frame_done,
  output logic [$clog2(IMG_ROWS)-1:0] o_row,
  output logic [$clog2(IMG_COLS)-1:0] o_col
);

  localparam int DEPTH = IMG_ROWS * IMG_COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(IMG_ROWS);
  localparam int CW    = $clog2(IMG_COLS);

`ifdef FEATURE_STREAMER_TEST_PATTERN_EN
  localparam bit START_UNLOADED = 1'b1;
`else
  localparam bit START_UNLOADED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state_q;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic                  loaded_q;
  logic                  busy_q;
  logic                  frame_done_q;

  // Issue side: address of the next buffer read and its coordinates.
  logic [AW-1:0]         raddr_q;
  logic [RW-1:0]         irow_q, irow_d;
  logic [CW-1:0]         icol_q, icol_d;
  logic                  issued_all_q;

  // Stage 1 holds the buffer read result; stage 2 is the output register.
  logic                  s1_valid_q;
  logic [RW-1:0]         s1_row_q;
  logic [CW-1:0]         s1_col_q;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [RW-1:0]         out_row_q;
  logic [CW-1:0]         out_col_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic load_fire, out_adv, rd_en, last_xfer, issue_last;

  assign o_load_ready = (state_q == IDLE);
  assign load_fire    = i_load_valid && o_load_ready;
  assign out_adv      = !out_valid_q || i_ready_feature;
  // Refill stage 1 whenever it is empty or drains this cycle: no bubbles under full ready.
  assign rd_en        = (state_q == STREAM) && !issued_all_q && (!s1_valid_q || out_adv);
  assign issue_last   = (irow_q == RW'(IMG_ROWS - 1)) && (icol_q == CW'(IMG_COLS - 1));
  assign last_xfer    = out_valid_q && i_ready_feature &&
                        (out_row_q == RW'(IMG_ROWS - 1)) && (out_col_q == CW'(IMG_COLS - 1));

  always_comb begin
    wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
    icol_d = icol_q + CW'(1);
    irow_d = irow_q;
    if (icol_q == CW'(IMG_COLS - 1)) begin
      icol_d = '0;
      irow_d = irow_q + RW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (load_fire) mem[wptr_q] <= i_load_data;
    if (rd_en)     rd_data_q   <= mem[raddr_q];
  end

`ifdef FEATURE_STREAMER_TEST_PATTERN_EN
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [AW-1:0] a);
    logic [AW+DATA_WIDTH-1:0] w;
    w = {{DATA_WIDTH{1'b0}}, a};
    return w[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] pat_q;
  always_ff @(posedge i_clk) begin
    if (rd_en) pat_q <= pattern(raddr_q);
  end
  assign s1_data = pat_q;
`else
  assign s1_data = rd_data_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      loaded_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      raddr_q      <= '0;
      irow_q       <= '0;
      icol_q       <= '0;
      issued_all_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_row_q     <= '0;
      s1_col_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_fire) begin
            wptr_q <= wptr_d;
            if (wptr_q == '0) loaded_q <= 1'b0;
            if (wptr_q == AW'(DEPTH - 1)) loaded_q <= 1'b1;
          end
          if (i_start && (loaded_q || START_UNLOADED)) begin
            state_q      <= STREAM;
            busy_q       <= 1'b1;
            raddr_q      <= '0;
            irow_q       <= '0;
            icol_q       <= '0;
            issued_all_q <= 1'b0;
            s1_valid_q   <= 1'b0;
          end
        end
        STREAM: begin
          if (out_adv) begin
            out_valid_q <= s1_valid_q;
            out_data_q  <= s1_data;
            out_row_q   <= s1_row_q;
            out_col_q   <= s1_col_q;
          end
          if (rd_en) begin
            s1_valid_q <= 1'b1;
            s1_row_q   <= irow_q;
            s1_col_q   <= icol_q;
            raddr_q    <= raddr_q + AW'(1);
            irow_q     <= irow_d;
            icol_q     <= icol_d;
            if (issue_last) issued_all_q <= 1'b1;
          end else if (out_adv) begin
            s1_valid_q <= 1'b0;
          end
          if (last_xfer) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_loaded        = loaded_q;
  assign o_busy          = busy_q;
  assign o_frame_done    = frame_done_q;
  assign o_feature_valid = out_valid_q;
  assign o_feature       = out_data_q;
  assign o_row           = out_row_q;
  assign o_col           = out_col_q;

endmodule

// File: tb/tb_feature_streamer.sv
// Directed bench for feature_streamer: load, stream with/without backpressure, interference, async reset.
module tb_feature_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       loaded;
  logic       start;
  logic       ready_feature;
  logic       feature_valid;
  logic [7:0] feature;
  logic       busy;
  logic       frame_done;
  logic [4:0] row;
  logic [4:0] col;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [7:0] got_beats [1024];

  always #5 clk = ~clk;

  feature_streamer dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_load_valid    (load_valid),
    .i_load_data     (load_data),
    .o_load_ready    (load_ready),
    .o_loaded        (loaded),
    .i_start         (start),
    .i_ready_feature (ready_feature),
    .o_feature_valid (feature_valid),
    .o_feature       (feature),
    .o_busy          (busy),
    .o_frame_done    (frame_done),
    .o_row           (row),
    .o_col           (col)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("chk %s: got %0d ok", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bytes(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered right after the edge that sampled i_start. rmode 0: ready always; 1: ready 1,0,0,1 repeating.
  task automatic run_stream(input string tag, input int rmode, input bit interfere);
    int k = 0, cyc = 0, first_cyc = -1;
    int seq_err = 0, hold_err = 0, busy_err = 0, lr_err = 0;
    bit stalled = 1'b0;
    logic [7:0] pd;
    logic [4:0] pr, pc;
    while (k < 1024 && cyc < 5000) begin
      if (stalled && (!feature_valid || feature !== pd || row !== pr || col !== pc)) hold_err++;
      if (first_cyc >= 0 && !feature_valid) hold_err++;
      if (!busy) busy_err++;
      if (interfere && load_ready) lr_err++;
      load_valid    = interfere;
      load_data     = 8'hFF;
      start         = interfere && (cyc == 10);
      ready_feature = (rmode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      stalled       = feature_valid && !ready_feature;
      pd = feature; pr = row; pc = col;
      if (feature_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (ready_feature) begin
          if (feature !== 8'(k) || row !== 5'(k / 32) || col !== 5'(k % 32)) seq_err++;
          got_beats[k] = feature;
          k++;
        end
      end
      tick();
      cyc++;
    end
    load_valid    = 1'b0;
    start         = 1'b0;
    ready_feature = 1'b0;
    chk({tag, "_latency"}, 32'(first_cyc), 32'd2);
    chk({tag, "_beats"}, 32'(k), 32'd1024);
    chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    chk({tag, "_hold_gap_err"}, 32'(hold_err), 32'd0);
    chk({tag, "_busy_err"}, 32'(busy_err), 32'd0);
    if (interfere) chk({tag, "_load_ready_err"}, 32'(lr_err), 32'd0);
    chk({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
    chk({tag, "_valid_after"}, 32'(feature_valid), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_cleared"}, 32'(frame_done), 32'd0);
    chk({tag, "_idle_load_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0; ready_feature = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_valid", 32'(feature_valid), 32'd0);
    chk("rst_feature", 32'(feature), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_row_col", {row, col}, 32'd0);

`ifdef FEATURE_STREAMER_TEST_PATTERN_EN
    pulse_start();
    run_stream("pattern", 0, 1'b0);
    chk("pattern_r3c5", 32'(got_beats[3 * 32 + 5]), 32'd101);
    chk("pattern_r8c0", 32'(got_beats[8 * 32]), 32'd0);
`else
    pulse_start();
    repeat (3) tick();
    chk("unloaded_start_valid", 32'(feature_valid), 32'd0);
    chk("unloaded_start_busy", 32'(busy), 32'd0);
    load_bytes(0, 1023);
    chk("partial_loaded", 32'(loaded), 32'd0);
    pulse_start();
    repeat (3) tick();
    chk("partial_start_valid", 32'(feature_valid), 32'd0);
    chk("partial_start_busy", 32'(busy), 32'd0);
    load_bytes(1023, 1);
    chk("full_loaded", 32'(loaded), 32'd1);

    pulse_start();
    run_stream("s_cont", 0, 1'b0);
    chk("s_cont_r3c5", 32'(got_beats[3 * 32 + 5]), 32'd101);
    chk("s_cont_r8c0", 32'(got_beats[8 * 32]), 32'd0);
    chk("s_cont_loaded", 32'(loaded), 32'd1);

    pulse_start();
    run_stream("s_stall", 1, 1'b0);

    pulse_start();
    run_stream("s_interf", 0, 1'b1);
    pulse_start();
    run_stream("s_restream", 0, 1'b0);
    chk("s_restream_loaded", 32'(loaded), 32'd1);

    begin
      int cyc = 0;
      bit reached = 1'b0;
      pulse_start();
      ready_feature = 1'b1;
      while (cyc < 2000 && !reached) begin
        if (feature_valid && row == 5'd15 && col == 5'd20) reached = 1'b1;
        else begin
          tick();
          cyc++;
        end
      end
      chk("arst_reached_beat500", 32'(reached), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(feature_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_feature", 32'(feature), 32'd0);
      chk("arst_row_col", {row, col}, 32'd0);
      chk("arst_load_ready", 32'(load_ready), 32'd1);
      ready_feature = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("arst_loaded_after", 32'(loaded), 32'd0);
      chk("arst_valid_after", 32'(feature_valid), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
